// File: rtl/rt_pkg.sv
// rt_pkg: shared types and constants for the ray/triangle return path.
//   Q_BITS   fractional bits of the fixed-point distance t
//   D_BITS   signed data word width
//   M_BITS   triangle ID width
//   TRI_MAX  last triangle ID per ray (TRI_MAX+1 results per ray)
//   T_MAX    largest positive signed D_BITS value, the "no hit yet" distance
package rt_pkg;

  localparam int Q_BITS  = 10;
  localparam int D_BITS  = 32;
  localparam int M_BITS  = 12;
  localparam int TRI_MAX = 11;

  localparam logic signed [D_BITS-1:0] T_MAX = {1'b0, {(D_BITS-1){1'b1}}};

  // One per-triangle intersection result, as popped from the result FIFO.
  typedef struct packed {
    logic                     hit;
    logic signed [D_BITS-1:0] t;
    logic [M_BITS-1:0]        tri_id;
  } hit_result_t;

  // Running / final closest hit of a ray; hit doubles as "any valid hit seen".
  typedef struct packed {
    logic                     hit;
    logic signed [D_BITS-1:0] t;
    logic [M_BITS-1:0]        tri_id;
  } closest_hit_t;

  localparam closest_hit_t BEST_INIT = '{hit: 1'b0, t: T_MAX, tri_id: '0};

  typedef enum logic [2:0] {
    S_WAIT = 3'd0,
    S_EVAL = 3'd1,
    S_EMIT = 3'd2
  } state_t;

endpackage

// File: rtl/hit_collector_hit_compare.sv
// hit_compare: combinational closest-hit reduction step.
//   cand       candidate result under evaluation
//   best       current closest hit of the ray
//   take       candidate replaces the current best
//   next_best  best after considering the candidate
// A candidate counts only when it hits in front of the origin (t > 0). It must
// be strictly closer than the current best, so on equal distance the earlier
// (lower) triangle ID is kept.
module hit_compare
  import rt_pkg::*;
(
  input  hit_result_t  cand,
  input  closest_hit_t best,
  output logic         take,
  output closest_hit_t next_best
);

  logic cand_valid;

  assign cand_valid = cand.hit && ($signed(cand.t) > $signed(D_BITS'(0)));
  assign take       = cand_valid && ($signed(cand.t) < $signed(best.t));

  always_comb begin
    next_best = best;
    if (take) begin
      next_best = '{hit: 1'b1, t: cand.t, tri_id: cand.tri_id};
    end
  end

endmodule

// File: rtl/hit_collector.sv
// hit_collector: drains per-triangle intersection results (TRI_MAX+1 per ray,
// in ID order) from a first-word-fall-through result FIFO and writes one
// closest-hit record per ray to the output FIFO.
//   clock, reset   system clock, asynchronous active-high reset
//   in_empty       result FIFO empty; in_* valid whenever low
//   in_rd_en       result FIFO pop, one cycle per consumed word
//   in_hit/in_t/in_tri_id   head result
//   out_full       output FIFO full
//   out_wr_en      output FIFO push, one cycle per ray
//   out_hit/out_t/out_tri_id  closest-hit record, held between pushes
//   seq_err        sticky: a triangle ID arrived out of sequence
// Optional build macro HIT_COLLECTOR_STATS_EN adds ray_count and hit_count.
// Ray framing is purely counter based: every consumed word fills one slot,
// whatever ID it carries, so a bad ID never changes the ray length.
module hit_collector
  import rt_pkg::*;
(
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     in_empty,
  output logic                     in_rd_en,
  input  logic                     in_hit,
  input  logic signed [D_BITS-1:0] in_t,
  input  logic [M_BITS-1:0]        in_tri_id,
  input  logic                     out_full,
  output logic                     out_wr_en,
  output logic                     out_hit,
  output logic signed [D_BITS-1:0] out_t,
  output logic [M_BITS-1:0]        out_tri_id,
  output logic                     seq_err
`ifdef HIT_COLLECTOR_STATS_EN
  ,
  output logic [31:0]              ray_count,
  output logic [31:0]              hit_count
`endif
);

  state_t                   state_q, state_d;
  hit_result_t              cand_q, cand_d;
  closest_hit_t             best_q, best_d, best_next;
  logic                     take;
  logic [M_BITS-1:0]        exp_id_q, exp_id_d;
  logic                     in_rd_en_d, out_wr_en_d, out_hit_d, seq_err_d;
  logic signed [D_BITS-1:0] out_t_d;
  logic [M_BITS-1:0]        out_tri_id_d;
`ifdef HIT_COLLECTOR_STATS_EN
  logic [31:0]              ray_count_d, hit_count_d;
`endif

  hit_compare u_hit_compare (
    .cand      (cand_q),
    .best      (best_q),
    .take      (take),
    .next_best (best_next)
  );

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    state_d      = state_q;
    cand_d       = cand_q;
    best_d       = best_q;
    exp_id_d     = exp_id_q;
    in_rd_en_d   = 1'b0;
    out_wr_en_d  = 1'b0;
    out_hit_d    = out_hit;
    out_t_d      = out_t;
    out_tri_id_d = out_tri_id;
    seq_err_d    = seq_err;
`ifdef HIT_COLLECTOR_STATS_EN
    ray_count_d  = ray_count;
    hit_count_d  = hit_count;
`endif

    case (state_q)
      S_WAIT: begin
        if (!in_empty) begin
          cand_d     = '{hit: in_hit, t: in_t, tri_id: in_tri_id};
          in_rd_en_d = 1'b1;
          state_d    = S_EVAL;
        end
      end

      S_EVAL: begin
        if (take) begin
          best_d = best_next;
        end
        if (cand_q.tri_id != exp_id_q) begin
          seq_err_d = 1'b1;
        end
        if (exp_id_q == M_BITS'(TRI_MAX)) begin
          state_d = S_EMIT;
        end else begin
          exp_id_d = exp_id_q + M_BITS'(1);
          state_d  = S_WAIT;
        end
      end

      S_EMIT: begin
        // While the output FIFO is full nothing moves; the record waits here.
        if (!out_full) begin
          out_wr_en_d  = 1'b1;
          out_hit_d    = best_q.hit;
          out_t_d      = best_q.hit ? best_q.t : '0;
          out_tri_id_d = best_q.hit ? best_q.tri_id : '0;
          best_d       = BEST_INIT;
          exp_id_d     = '0;
          state_d      = S_WAIT;
`ifdef HIT_COLLECTOR_STATS_EN
          ray_count_d  = ray_count + 32'd1;
          if (best_q.hit) begin
            hit_count_d = hit_count + 32'd1;
          end
`endif
        end
      end

      default: begin
        // Unused encodings recover exactly as a reset would.
        state_d      = S_WAIT;
        cand_d       = '0;
        best_d       = BEST_INIT;
        exp_id_d     = '0;
        out_hit_d    = 1'b0;
        out_t_d      = '0;
        out_tri_id_d = '0;
        seq_err_d    = 1'b0;
`ifdef HIT_COLLECTOR_STATS_EN
        ray_count_d  = '0;
        hit_count_d  = '0;
`endif
      end
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= S_WAIT;
      cand_q     <= '0;
      best_q     <= BEST_INIT;
      exp_id_q   <= '0;
      in_rd_en   <= 1'b0;
      out_wr_en  <= 1'b0;
      out_hit    <= 1'b0;
      out_t      <= '0;
      out_tri_id <= '0;
      seq_err    <= 1'b0;
`ifdef HIT_COLLECTOR_STATS_EN
      ray_count  <= '0;
      hit_count  <= '0;
`endif
    end else begin
      state_q    <= state_d;
      cand_q     <= cand_d;
      best_q     <= best_d;
      exp_id_q   <= exp_id_d;
      in_rd_en   <= in_rd_en_d;
      out_wr_en  <= out_wr_en_d;
      out_hit    <= out_hit_d;
      out_t      <= out_t_d;
      out_tri_id <= out_tri_id_d;
      seq_err    <= seq_err_d;
`ifdef HIT_COLLECTOR_STATS_EN
      ray_count  <= ray_count_d;
      hit_count  <= hit_count_d;
`endif
    end
  end

endmodule
